branch_cond_unit: RTL and testbench

//  Consumer side of the N/Z/V flag interface: resolves conditional branches in the EX stage.

---
 rtl/branch_cond_unit_if.sv | 44 ++++
 rtl/branch_cond_unit.sv | 87 ++++++++
 tb/tb_branch_cond_unit.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_cond_unit_if.sv
// EX-stage branch interface: branch operands, flag register/ALU bypass flags in; resolution out.
interface branch_cond_unit_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned OFF_W  = 9,
  parameter int unsigned CNT_W  = 16
);
  logic              br_valid;
  logic              br_is_reg;
  logic [2:0]        cond;
  logic [OFF_W-1:0]  offset;
  logic [ADDR_W-1:0] pc_plus2;
  logic [ADDR_W-1:0] reg_target;
  logic              n_flag;
  logic              z_flag;
  logic              v_flag;
  logic              alu_n;
  logic              alu_z;
  logic              alu_v;
  logic              alu_n_en;
  logic              alu_z_en;
  logic              alu_v_en;
  logic              flag_pending;
  logic              stall;
  logic              br_busy;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              flush;
  logic [CNT_W-1:0]  br_count;
  logic [CNT_W-1:0]  taken_count;

  modport master (
    output br_valid, br_is_reg, cond, offset, pc_plus2, reg_target,
    output n_flag, z_flag, v_flag, alu_n, alu_z, alu_v, alu_n_en, alu_z_en, alu_v_en,
    output flag_pending, stall,
    input  br_busy, br_taken, br_target, flush, br_count, taken_count
  );

  modport slave (
    input  br_valid, br_is_reg, cond, offset, pc_plus2, reg_target,
    input  n_flag, z_flag, v_flag, alu_n, alu_z, alu_v, alu_n_en, alu_z_en, alu_v_en,
    input  flag_pending, stall,
    output br_busy, br_taken, br_target, flush, br_count, taken_count
  );
endinterface

// File: rtl/branch_cond_unit.sv
// Resolves conditional branches in EX using bypassed N/Z/V flags; waits on pending flag writers
// and emits a registered taken/target plus a stall-safe flush pulse toward fetch.
module branch_cond_unit #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned OFF_W  = 9,
  parameter int unsigned CNT_W  = 16
) (
  input logic               clk,
  input logic               rst_n,
  branch_cond_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWait, StResult} state_e;

  state_e            state_q;
  logic              taken_q;
  logic [ADDR_W-1:0] target_q;
  logic [CNT_W-1:0]  br_cnt_q;
  logic [CNT_W-1:0]  taken_cnt_q;

  logic              n_eff, z_eff, v_eff;
  logic              cond_true;
  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] target;
  logic              in_wait, present, resolve, go_wait;

  assign n_eff = bus.alu_n_en ? bus.alu_n : bus.n_flag;
  assign z_eff = bus.alu_z_en ? bus.alu_z : bus.z_flag;
  assign v_eff = bus.alu_v_en ? bus.alu_v : bus.v_flag;

  always_comb begin
    cond_true = 1'b0;
    case (bus.cond)
      3'b000:  cond_true = !z_eff;
      3'b001:  cond_true = z_eff;
      3'b010:  cond_true = !z_eff && !n_eff;
      3'b011:  cond_true = n_eff;
      3'b100:  cond_true = z_eff || (!z_eff && !n_eff);
      3'b101:  cond_true = n_eff || z_eff;
      3'b110:  cond_true = v_eff;
      default: cond_true = 1'b1;
    endcase
  end

  // Sign-extended word offset, already scaled to bytes.
  assign off_ext = {{(ADDR_W-OFF_W-1){bus.offset[OFF_W-1]}}, bus.offset, 1'b0};
  assign target  = bus.br_is_reg ? bus.reg_target : bus.pc_plus2 + off_ext;

  // In WAIT the branch operands are held upstream, so br_valid is not re-qualified.
  assign in_wait = (state_q == StWait);
  assign present = in_wait | bus.br_valid;
  assign resolve = present & !bus.flag_pending & !bus.stall;
  assign go_wait = !in_wait & bus.br_valid & bus.flag_pending & !bus.stall;

  assign bus.br_busy     = in_wait ? (bus.flag_pending | bus.stall)
                                   : (bus.br_valid & bus.flag_pending);
  assign bus.br_taken    = taken_q;
  assign bus.br_target   = target_q;
  assign bus.flush       = taken_q & !bus.stall;
  assign bus.br_count    = br_cnt_q;
  assign bus.taken_count = taken_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      taken_q     <= 1'b0;
      target_q    <= '0;
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else if (!bus.stall) begin
      if (resolve) begin
        state_q  <= StResult;
        taken_q  <= cond_true;
        target_q <= target;
        if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + CNT_W'(1);
        if (cond_true && (taken_cnt_q != '1)) taken_cnt_q <= taken_cnt_q + CNT_W'(1);
      end else if (go_wait) begin
        state_q <= StWait;
        taken_q <= 1'b0;
      end else if (!in_wait) begin
        state_q <= StIdle;
        taken_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Bench for branch_cond_unit: directed spot checks plus randomized traffic against a
// transaction-level model of branch resolution.
module tb_branch_cond_unit;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned OFF_W  = 9;
  localparam int unsigned CNT_W  = 8;
  localparam int          CMAX   = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  branch_cond_unit_if #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .CNT_W(CNT_W)) bif ();

  branch_cond_unit #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: an outstanding (waiting) branch, and the result presented this cycle.
  bit m_live   = 1'b0;
  bit m_taken  = 1'b0;
  int m_target = 0;
  int m_brc    = 0;
  int m_tkc    = 0;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endfunction

  function automatic bit holds(int c, bit n, bit z, bit v);
    case (c)
      0:       return !z;
      1:       return z;
      2:       return !z && !n;
      3:       return n;
      4:       return z || (!z && !n);
      5:       return n || z;
      6:       return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit model_taken();
    bit n = bif.alu_n_en ? bif.alu_n : bif.n_flag;
    bit z = bif.alu_z_en ? bif.alu_z : bif.z_flag;
    bit v = bif.alu_v_en ? bif.alu_v : bif.v_flag;
    return holds(int'(bif.cond), n, z, v);
  endfunction

  function automatic int model_dest();
    int o = int'(bif.offset);
    if (o >= (1 << (OFF_W - 1))) o -= (1 << OFF_W);
    if (bif.br_is_reg) return int'(bif.reg_target);
    return (int'(bif.pc_plus2) + 2 * o) & ((1 << ADDR_W) - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_live   <= 1'b0;
      m_taken  <= 1'b0;
      m_target <= 0;
      m_brc    <= 0;
      m_tkc    <= 0;
    end else if (!bif.stall) begin
      if ((m_live || bif.br_valid) && !bif.flag_pending) begin
        m_live   <= 1'b0;
        m_taken  <= model_taken();
        m_target <= model_dest();
        m_brc    <= (m_brc == CMAX) ? CMAX : m_brc + 1;
        if (model_taken()) m_tkc <= (m_tkc == CMAX) ? CMAX : m_tkc + 1;
      end else begin
        m_taken <= 1'b0;
        if (bif.br_valid && bif.flag_pending) m_live <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", int'(bif.br_busy),
            m_live ? int'(bif.flag_pending | bif.stall) : int'(bif.br_valid & bif.flag_pending));
      check("flush", int'(bif.flush), int'(m_taken && !bif.stall));
      check("taken", int'(bif.br_taken), int'(m_taken));
      if (m_taken) check("target", int'(bif.br_target), m_target);
      check("br_count", int'(bif.br_count), m_brc);
      check("taken_count", int'(bif.taken_count), m_tkc);
    end
  end

  task automatic quiet();
    bif.br_valid = 1'b0;  bif.br_is_reg = 1'b0;  bif.cond = 3'd0;  bif.offset = '0;
    bif.pc_plus2 = '0;    bif.reg_target = '0;
    bif.n_flag = 1'b0;    bif.z_flag = 1'b0;     bif.v_flag = 1'b0;
    bif.alu_n = 1'b0;     bif.alu_z = 1'b0;      bif.alu_v = 1'b0;
    bif.alu_n_en = 1'b0;  bif.alu_z_en = 1'b0;   bif.alu_v_en = 1'b0;
    bif.flag_pending = 1'b0;  bif.stall = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset(string tag);
    check({tag, "_taken"}, int'(bif.br_taken), 0);
    check({tag, "_target"}, int'(bif.br_target), 0);
    check({tag, "_flush"}, int'(bif.flush), 0);
    check({tag, "_busy"}, int'(bif.br_busy), 0);
    check({tag, "_brc"}, int'(bif.br_count), 0);
    check({tag, "_tkc"}, int'(bif.taken_count), 0);
  endtask

  initial begin
    quiet();
    #1 rst_n = 1'b0;
    #1 check_reset("rst");
    #20;
    @(negedge clk) rst_n = 1'b1;
    step();
    cmp_en = 1'b1;

    // Z from register, EQ, +4 words from 0x0100.
    bif.z_flag = 1'b1;  bif.cond = 3'b001;  bif.offset = 9'd4;  bif.pc_plus2 = 16'h0100;
    bif.br_valid = 1'b1;
    step();
    bif.br_valid = 1'b0;  bif.z_flag = 1'b0;
    #1;
    check("eq_taken", int'(bif.br_taken), 1);
    check("eq_target", int'(bif.br_target), 16'h0108);
    check("eq_flush", int'(bif.flush), 1);
    step();
    check("eq_flush_end", int'(bif.flush), 0);

    // ALU bypass of Z overrides the register value.
    bif.cond = 3'b000;  bif.alu_z_en = 1'b1;  bif.alu_z = 1'b1;  bif.br_valid = 1'b1;
    step();
    bif.br_valid = 1'b0;  bif.alu_z_en = 1'b0;  bif.alu_z = 1'b0;
    #1;
    check("byp_taken", int'(bif.br_taken), 0);
    check("byp_flush", int'(bif.flush), 0);
    check("byp_brc", int'(bif.br_count), 2);

    // Wait three cycles on an older flag writer; N then arrives from the ALU.
    bif.cond = 3'b011;  bif.offset = 9'h1F0;  bif.pc_plus2 = 16'h0200;
    bif.flag_pending = 1'b1;  bif.br_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("wait_busy", int'(bif.br_busy), 1);
      step();
    end
    bif.flag_pending = 1'b0;  bif.alu_n_en = 1'b1;  bif.alu_n = 1'b1;
    #1 check("wait_release_busy", int'(bif.br_busy), 0);
    step();
    bif.br_valid = 1'b0;  bif.alu_n_en = 1'b0;  bif.alu_n = 1'b0;
    #1;
    check("wait_taken", int'(bif.br_taken), 1);
    check("wait_target", int'(bif.br_target), 16'h01E0);

    // Register target, then PC-relative wrap below zero, back to back.
    bif.br_is_reg = 1'b1;  bif.reg_target = 16'hFFFE;  bif.cond = 3'b111;  bif.br_valid = 1'b1;
    step();
    #1 check("br_target", int'(bif.br_target), 16'hFFFE);
    bif.br_is_reg = 1'b0;  bif.offset = 9'h1FF;  bif.pc_plus2 = 16'h0000;
    step();
    bif.br_valid = 1'b0;
    #1;
    check("wrap_taken", int'(bif.br_taken), 1);
    check("wrap_target", int'(bif.br_target), 16'hFFFE);
    step();

    // Taken result held through a 2-cycle stall; flush appears once afterwards.
    bif.cond = 3'b111;  bif.pc_plus2 = 16'h1234;  bif.offset = 9'd3;  bif.br_valid = 1'b1;
    step();
    bif.br_valid = 1'b0;  bif.stall = 1'b1;
    #1 check("stall_flush0", int'(bif.flush), 0);
    check("stall_taken0", int'(bif.br_taken), 1);
    step();
    #1 check("stall_flush1", int'(bif.flush), 0);
    check("stall_taken1", int'(bif.br_taken), 1);
    bif.stall = 1'b0;
    #1 check("stall_flush_late", int'(bif.flush), 1);
    check("stall_target", int'(bif.br_target), 16'h123A);
    step();
    #1 check("stall_flush_done", int'(bif.flush), 0);

    // Counter saturation from a clean reset.
    rst_n = 1'b0;
    quiet();
    @(negedge clk) rst_n = 1'b1;
    step();
    bif.cond = 3'b111;  bif.br_is_reg = 1'b1;  bif.reg_target = 16'h0040;  bif.br_valid = 1'b1;
    repeat (CMAX + 5) step();
    bif.br_valid = 1'b0;
    #1;
    check("sat_tkc", int'(bif.taken_count), CMAX);
    check("sat_brc", int'(bif.br_count), CMAX);
    step();

    // Reset while a branch is waiting discards it.
    bif.cond = 3'b011;  bif.n_flag = 1'b1;  bif.flag_pending = 1'b1;  bif.br_valid = 1'b1;
    step();
    step();
    #1 check("midwait_busy", int'(bif.br_busy), 1);
    rst_n = 1'b0;
    bif.br_valid = 1'b0;  bif.flag_pending = 1'b0;
    #1 check_reset("midwait_rst");
    @(negedge clk) rst_n = 1'b1;
    step();
    #1 check("midwait_discard", int'(bif.br_taken), 0);
    bif.n_flag = 1'b0;

    // Randomized traffic; a waiting branch keeps its operands stable.
    for (int c = 0; c < 3000; c++) begin
      if (!m_live) begin
        bif.br_valid   = ($urandom_range(0, 9) < 6);
        bif.br_is_reg  = 1'($urandom_range(0, 1));
        bif.cond       = 3'($urandom_range(0, 7));
        bif.offset     = OFF_W'($urandom);
        bif.pc_plus2   = ADDR_W'($urandom);
        bif.reg_target = ADDR_W'($urandom);
      end
      bif.n_flag = 1'($urandom_range(0, 1));    bif.z_flag = 1'($urandom_range(0, 1));
      bif.v_flag = 1'($urandom_range(0, 1));    bif.alu_n = 1'($urandom_range(0, 1));
      bif.alu_z = 1'($urandom_range(0, 1));     bif.alu_v = 1'($urandom_range(0, 1));
      bif.alu_n_en = 1'($urandom_range(0, 1));  bif.alu_z_en = 1'($urandom_range(0, 1));
      bif.alu_v_en = 1'($urandom_range(0, 1));
      bif.flag_pending = ($urandom_range(0, 3) == 0);
      bif.stall        = ($urandom_range(0, 4) == 0);
      step();
    end

    quiet();
    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
